vcr_shared_bank_lender: RTL
===========================

// Module: vcr_shared_bank_lender
// PURPOSE
// - Lends a parametrised pool of shared input-buffer banks to router input ports for dynamic-VC overflow.
// - Each bank is granted to at most one port at a time; each port holds at most one bank.
// - Per-bank occupancy is tracked from write and free events so that banks are reclaimed only when empty.
// - Sits between the per-port shared-VC request logic and the shared buffer memory.
// - Generalises the single fixed-threshold bank grant to N banks, configurable depth, hold-off release and error detection.
// PARAMETERS
// num_ports      5   router input ports competing for banks
// num_banks      2   shared banks in the pool (1..num_ports)
// bank_depth     8   flit slots per bank; occupancy counter width = clogb(bank_depth+1)
// release_delay  4   idle cycles an empty, unrequested bank waits before return to FREE (>=1)
// PORTS
// clk             in   1                   clock
// reset           in   1                   synchronous, active-high
// bank_req_ip     in   num_ports           port requests, or keeps requesting, a shared bank
// shared_write_ip in   num_ports           port wrote one flit into its granted bank this cycle
// shared_free_ip  in   num_ports           one flit left the port's bank this cycle (credit return)
// bank_grant_op   out  num_ports*num_banks one-hot per port; bit [p*num_banks+b] = bank b owned by port p
// shared_credit_op out num_ports           port owns a bank and that bank's occupancy < bank_depth
// bank_busy       out  num_banks           bank state != FREE
// error           out  1                   sticky protocol error
// BEHAVIOUR
// Reset
// - All outputs are 0. All banks are FREE. Occupancy is 0. The round-robin pointer is 0.
// Bank FSM: FREE -> LENT -> DRAINING -> FREE
// - FREE: a bank receives at most one new grant per cycle, across the whole pool.
//   - The arbiter is round-robin over ports with bank_req_ip=1 that own no bank.
//   - The lowest-index FREE bank is granted.
//   - bank_grant_op and bank_busy rise the cycle after the request is sampled (1-cycle latency).
//   - The pointer advances to winner+1 mod num_ports.
// - LENT:
//   - occ += shared_write_ip[owner]; occ -= shared_free_ip[owner].
//   - Simultaneous write and free leaves occ unchanged.
//   - Transition to DRAINING when bank_req_ip[owner]=0 and next occ==0; load idle counter = release_delay.
// - DRAINING:
//   - Grant stays asserted.
//   - If bank_req_ip[owner]=1 or a write occurs, return to LENT.
//   - Otherwise decrement the idle counter. At 1, go to FREE next cycle and clear the grant and owner.
// - A bank returning to FREE is not re-granted in the same cycle. It is eligible from the next cycle.
// shared_credit_op
// - Combinational from registered state: 1 iff the owned bank is LENT/DRAINING and occ < bank_depth.
// error (set next cycle, cleared only by reset). Set on any of:
// - write when occ==bank_depth
// - free when occ==0
// - write or free from a port owning no bank
// Error conditions
// - Offending events do not change occupancy: saturate at 0 / bank_depth.
// Reset mid-operation
// - All grants drop on the cycle after reset is sampled.
// - Occupancy is discarded. Upstream must flush its shared-VC state on reset.
// TESTING
// 1. Reset, then bank_req_ip=5'b00100 -> next cycle bank_grant_op[2*2+0]=1, bank_busy=2'b01, shared_credit_op[2]=1.
// 2. Ports 0,1,3 request together with 2 banks ->
//    - port 0 gets bank 0 at cycle 1, port 1 gets bank 1 at cycle 2;
//    - port 3 waits until a bank frees, then is granted.
// 3. Owner writes 8 flits -> shared_credit_op drops after the 8th write.
//    - A 9th write sets error, occ stays 8.
//    - Simultaneous write+free at full keeps occ=8, no error.
// 4. Owner drops req with occ=0 -> DRAINING, bank_busy stays 1 for release_delay=4 cycles, then grant and busy go 0.
//    - Re-request at idle count 2 returns the bank to LENT with the same owner.
// 5. shared_free_ip from a port with no bank -> error=1 next cycle and sticky; other banks' occupancy is unchanged.
// 6. Assert reset while 2 banks are LENT with occ 3 and 5 -> all grants, busy and error are 0 next cycle, and a fresh request is granted bank 0.

Source files
------------

// File: rtl/vcr_shared_bank_lender.sv
// vcr_shared_bank_lender
// Lends a pool of shared input-buffer banks to router input ports so that dynamic
// VCs can overflow into them. Each bank has at most one owner, and each port owns
// at most one bank. Each bank tracks its occupancy from the owner's write and free
// events, so a bank goes back to the pool only once it is empty and has been idle.
//
// Ports:
//   clk              clock
//   reset            synchronous, active-high
//   bank_req_ip      per-port request, or continued hold, of a shared bank
//   shared_write_ip  per-port flit written into its granted bank this cycle
//   shared_free_ip   per-port flit left its granted bank this cycle
//   bank_grant_op    bit [p*num_banks+b] set when bank b is owned by port p
//   shared_credit_op port owns a bank that still has room for a flit
//   bank_busy        per-bank state is not FREE
//   error            sticky protocol error, cleared only by reset
module vcr_shared_bank_lender #(
  parameter int unsigned num_ports     = 5,
  parameter int unsigned num_banks     = 2,
  parameter int unsigned bank_depth    = 8,
  parameter int unsigned release_delay = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_ports-1:0]           bank_req_ip,
  input  logic [num_ports-1:0]           shared_write_ip,
  input  logic [num_ports-1:0]           shared_free_ip,
  output logic [num_ports*num_banks-1:0] bank_grant_op,
  output logic [num_ports-1:0]           shared_credit_op,
  output logic [num_banks-1:0]           bank_busy,
  output logic                           error
);

  localparam int unsigned PortW = (num_ports > 1) ? $clog2(num_ports) : 1;
  localparam int unsigned BankW = (num_banks > 1) ? $clog2(num_banks) : 1;
  localparam int unsigned OccW  = $clog2(bank_depth + 1);
  localparam int unsigned IdleW = $clog2(release_delay + 1);

  localparam logic [OccW-1:0]  OccMax   = OccW'(bank_depth);
  localparam logic [IdleW-1:0] IdleLoad = IdleW'(release_delay);
  localparam logic [PortW-1:0] LastPort = PortW'(num_ports - 1);

  typedef enum logic [1:0] {StFree, StLent, StDraining} bank_st_e;

  bank_st_e         state_q [num_banks];
  bank_st_e         state_d [num_banks];
  logic [PortW-1:0] owner_q [num_banks];
  logic [PortW-1:0] owner_d [num_banks];
  logic [OccW-1:0]  occ_q   [num_banks];
  logic [OccW-1:0]  occ_d   [num_banks];
  logic [IdleW-1:0] idle_q  [num_banks];
  logic [IdleW-1:0] idle_d  [num_banks];
  logic [PortW-1:0] rr_q, rr_d;
  logic             error_q, error_d;

  // Per-port ownership and owner events steered to each bank
  logic [num_ports-1:0] port_has_bank;
  logic [num_banks-1:0] bank_rq, bank_wr, bank_fr;

  always_comb begin
    bank_grant_op    = '0;
    shared_credit_op = '0;
    bank_busy        = '0;
    port_has_bank    = '0;
    bank_rq          = '0;
    bank_wr          = '0;
    bank_fr          = '0;
    for (int b = 0; b < num_banks; b++) begin
      if (state_q[b] != StFree) begin
        bank_busy[b] = 1'b1;
        for (int p = 0; p < num_ports; p++) begin
          if (owner_q[b] == PortW'(p)) begin
            bank_grant_op[p*num_banks+b] = 1'b1;
            port_has_bank[p]             = 1'b1;
            bank_rq[b]                   = bank_req_ip[p];
            bank_wr[b]                   = shared_write_ip[p];
            bank_fr[b]                   = shared_free_ip[p];
            if (occ_q[b] < OccMax) shared_credit_op[p] = 1'b1;
          end
        end
      end
    end
  end

  // Round-robin winner among requesting ports that own nothing, and the
  // lowest-index FREE bank. Descending loops leave the lowest index selected.
  logic [num_ports-1:0] cand;
  logic                 hi_valid, lo_valid, win_valid, free_valid;
  logic [PortW-1:0]     hi_port, lo_port, win_port;
  logic [BankW-1:0]     free_bank;

  assign cand = bank_req_ip & ~port_has_bank;

  always_comb begin
    hi_valid   = 1'b0;
    lo_valid   = 1'b0;
    hi_port    = '0;
    lo_port    = '0;
    free_valid = 1'b0;
    free_bank  = '0;
    for (int p = num_ports - 1; p >= 0; p--) begin
      if (cand[p]) begin
        lo_valid = 1'b1;
        lo_port  = PortW'(p);
        if (PortW'(p) >= rr_q) begin
          hi_valid = 1'b1;
          hi_port  = PortW'(p);
        end
      end
    end
    for (int b = num_banks - 1; b >= 0; b--) begin
      if (state_q[b] == StFree) begin
        free_valid = 1'b1;
        free_bank  = BankW'(b);
      end
    end
  end

  assign win_valid = hi_valid | lo_valid;
  assign win_port  = hi_valid ? hi_port : lo_port;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    occ_d   = occ_q;
    idle_d  = idle_q;
    rr_d    = rr_q;
    error_d = error_q;

    for (int p = 0; p < num_ports; p++) begin
      if ((shared_write_ip[p] || shared_free_ip[p]) && !port_has_bank[p]) error_d = 1'b1;
    end

    for (int b = 0; b < num_banks; b++) begin
      unique case (state_q[b])
        StFree: begin
          if (win_valid && free_valid && (free_bank == BankW'(b))) begin
            state_d[b] = StLent;
            owner_d[b] = win_port;
            occ_d[b]   = '0;
          end
        end
        StLent, StDraining: begin
          // Offending events leave occupancy saturated at 0 / bank_depth
          if (bank_wr[b] && !bank_fr[b]) begin
            if (occ_q[b] == OccMax) error_d = 1'b1;
            else                    occ_d[b] = occ_q[b] + 1'b1;
          end else if (bank_fr[b] && !bank_wr[b]) begin
            if (occ_q[b] == '0) error_d = 1'b1;
            else                occ_d[b] = occ_q[b] - 1'b1;
          end

          if (state_q[b] == StLent) begin
            if (!bank_rq[b] && (occ_d[b] == '0)) begin
              state_d[b] = StDraining;
              idle_d[b]  = IdleLoad;
            end
          end else if (bank_rq[b] || bank_wr[b]) begin
            state_d[b] = StLent;
          end else if (idle_q[b] <= IdleW'(1)) begin
            state_d[b] = StFree;
            owner_d[b] = '0;
            occ_d[b]   = '0;
            idle_d[b]  = '0;
          end else begin
            idle_d[b] = idle_q[b] - 1'b1;
          end
        end
        default: begin
          state_d[b] = StFree;
        end
      endcase
    end

    if (win_valid && free_valid) begin
      rr_d = (win_port == LastPort) ? '0 : win_port + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < num_banks; b++) begin
        state_q[b] <= StFree;
        owner_q[b] <= '0;
        occ_q[b]   <= '0;
        idle_q[b]  <= '0;
      end
      rr_q    <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      occ_q   <= occ_d;
      idle_q  <= idle_d;
      rr_q    <= rr_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;

endmodule
